excp_ctrl: RTL

EXCP_CTRL -- requirements
Module: excp_ctrl

---
 rtl/excp_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/excp_ctrl.sv
// excp_ctrl: commit-stage trap sequencer.
// Accepts one trap event (interrupt, exception or ertn) from the commit
// instruction. It then holds flush for FLUSH_CYCLES cycles and issues a
// single-cycle fetch redirect before returning to IDLE.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   commit_valid/pc/excp/ertn     commit instruction and its trap flags
//   commit_ecode/subecode/badv    exception record of the commit instruction
//   crmd_ie, ecfg_lie, estat_is   interrupt enable, local enables, pending bits
//   eentry_va, tlbrentry_va       trap vectors (sampled in the REDIRECT cycle)
//   era_pc                        ertn return PC (sampled at the event edge)
//   commit_ready                  commit instruction accepted (state IDLE)
//   is_exception, is_ertn         one-cycle pulses to the CSR unit
//   ecode, subecode               latched trap record
//   exception_pc, exception_addr  latched trap record
//   flush                         kill all in-flight pipeline stages
//   redirect_valid, redirect_pc   fetch redirect
module excp_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        commit_excp,
  input  logic [5:0]  commit_ecode,
  input  logic [8:0]  commit_subecode,
  input  logic [31:0] commit_badv,
  input  logic        commit_ertn,
  input  logic        crmd_ie,
  input  logic [11:0] ecfg_lie,
  input  logic [11:0] estat_is,
  input  logic [31:0] eentry_va,
  input  logic [31:0] tlbrentry_va,
  input  logic [31:0] era_pc,
  output logic        commit_ready,
  output logic        is_exception,
  output logic        is_ertn,
  output logic [5:0]  ecode,
  output logic [8:0]  subecode,
  output logic [31:0] exception_pc,
  output logic [31:0] exception_addr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REDIRECT
  } state_t;

  localparam logic [3:0] LAST_CNT   = 4'(FLUSH_CYCLES - 1);
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  flush_cnt;
  logic [3:0]  flush_cnt_nxt;
  logic        int_req_q;
  logic        trap_is_ertn;
  logic [31:0] ertn_target;
  logic        trap_event;

  assign commit_ready = (state == IDLE);
  assign trap_event   = commit_valid & commit_ready &
                        (int_req_q | commit_excp | commit_ertn);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      IDLE: begin
        if (trap_event) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = '0;
        end
      end
      FLUSH: begin
        if (flush_cnt == LAST_CNT) begin
          state_nxt     = REDIRECT;
          flush_cnt_nxt = '0;
        end else begin
          flush_cnt_nxt = flush_cnt + 4'd1;
        end
      end
      REDIRECT: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Interrupt request is registered so that detection is one cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_req_q <= 1'b0;
    end else begin
      int_req_q <= crmd_ie & (|(ecfg_lie & estat_is));
    end
  end

  // Trap record. The priority is interrupt, then exception, then ertn.
  // An ertn leaves the exception record untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      ecode          <= '0;
      subecode       <= '0;
      exception_pc   <= '0;
      exception_addr <= '0;
      trap_is_ertn   <= 1'b0;
      ertn_target    <= '0;
    end else if (trap_event) begin
      if (int_req_q) begin
        ecode          <= '0;
        subecode       <= '0;
        exception_pc   <= commit_pc;
        exception_addr <= '0;
        trap_is_ertn   <= 1'b0;
      end else if (commit_excp) begin
        ecode          <= commit_ecode;
        subecode       <= commit_subecode;
        exception_pc   <= commit_pc;
        exception_addr <= commit_badv;
        trap_is_ertn   <= 1'b0;
      end else begin
        trap_is_ertn   <= 1'b1;
        ertn_target    <= era_pc;
      end
    end
  end

  // Output decode. The trap vectors are read live in REDIRECT so that
  // CSR writes made during FLUSH take effect.
  always_comb begin
    is_exception   = 1'b0;
    is_ertn        = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      FLUSH: begin
        flush = 1'b1;
        if (flush_cnt == 4'd0) begin
          is_exception = ~trap_is_ertn;
          is_ertn      = trap_is_ertn;
        end
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        if (trap_is_ertn)
          redirect_pc = ertn_target;
        else if (ecode == ECODE_TLBR)
          redirect_pc = tlbrentry_va;
        else
          redirect_pc = eentry_va;
      end
      default: ;
    endcase
  end

endmodule
